// File: rtl/adder_if.sv
// Operand/result bundle for the registered add/sub element.
// The master drives operands and mode; the slave (the adder) returns the result.
interface adder_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             flag;
  logic [WIDTH:0]   z;

  modport master (output x, output y, output flag, input z);
  modport slave  (input x, input y, input flag, output z);
endinterface

// File: rtl/adder.sv
// Registered two's-complement adder/subtractor built from a ripple chain
// of full-adder cells. The result is one bit wider than the operands.
module adder #(
  parameter int WIDTH = 8
) (
  input  logic   clk,
  input  logic   rst,
  adder_if.slave bus
);

  logic [WIDTH:0] a;
  logic [WIDTH:0] b;
  logic [WIDTH:0] s;
  logic [WIDTH:0] c;

  // Subtract is add of the inverted operand with carry-in set.
  assign a    = {bus.x[WIDTH-1], bus.x};
  assign b    = {bus.y[WIDTH-1], bus.y} ^ {(WIDTH+1){~bus.flag}};
  assign c[0] = ~bus.flag;

  for (genvar i = 0; i <= WIDTH; i++) begin : g_fa
    assign s[i] = a[i] ^ b[i] ^ c[i];
    // The top cell's carry-out is not needed: the extension bit absorbs it.
    if (i < WIDTH) begin : g_carry
      assign c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.z <= '0;
    end else begin
      bus.z <= s;
    end
  end

endmodule

// File: tb/tb_adder.sv
// Self-checking bench for adder: directed corner cases plus random operands
// checked against a plain integer-arithmetic reference.
module tb_adder;

  localparam int WIDTH = 8;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [WIDTH:0] prev;

  adder_if #(.WIDTH(WIDTH)) bus ();

  adder #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [WIDTH:0] ref_model(input logic [WIDTH-1:0] xv,
                                               input logic [WIDTH-1:0] yv,
                                               input logic fv);
    int r;
    if (fv) r = int'($signed(xv)) + int'($signed(yv));
    else    r = int'($signed(xv)) - int'($signed(yv));
    return r[WIDTH:0];
  endfunction

  task automatic check(input string tag, input logic [WIDTH:0] obs,
                       input logic [WIDTH:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive between edges, confirm z holds its old value, then check after the edge.
  task automatic step(input logic [WIDTH-1:0] xv, input logic [WIDTH-1:0] yv,
                      input logic fv, input logic [WIDTH:0] exp, input string tag);
    @(negedge clk);
    bus.x    = xv;
    bus.y    = yv;
    bus.flag = fv;
    #1;
    check({tag, "_hold"}, bus.z, prev);
    @(posedge clk);
    #1;
    check(tag, bus.z, exp);
    prev = exp;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [WIDTH-1:0] rx;
    logic [WIDTH-1:0] ry;
    logic             rf;
    checks   = 0;
    errors   = 0;
    prev     = '0;
    rst      = 1'b1;
    bus.x    = 8'h7F;
    bus.y    = 8'h7F;
    bus.flag = 1'b1;
    #2 rst = 1'b0;
    #1 check("reset_async", bus.z, 9'h000);

    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 check("reset_hold", bus.z, 9'h000);
    end

    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 check("reset_release", bus.z, 9'h0FE);
    prev = 9'h0FE;

    step(8'h08, 8'hFB, 1'b1, 9'h003, "add_8_m5");
    step(8'hC0, 8'h20, 1'b1, 9'h1E0, "add_m64_32");
    step(8'hFF, 8'hFF, 1'b1, 9'h1FE, "add_m1_m1");
    step(8'h80, 8'hFF, 1'b1, 9'h17F, "add_m128_m1");
    step(8'h7F, 8'h01, 1'b1, 9'h080, "add_127_1");
    step(8'h80, 8'h80, 1'b1, 9'h100, "add_m128_m128");
    step(8'h08, 8'h05, 1'b0, 9'h003, "sub_8_5");
    step(8'h80, 8'h01, 1'b0, 9'h17F, "sub_m128_1");
    step(8'h7F, 8'h80, 1'b0, 9'h0FF, "sub_127_m128");
    step(8'h80, 8'h7F, 1'b0, 9'h101, "sub_m128_127");
    step(8'h10, 8'h04, 1'b1, 9'h014, "b2b_add0");
    step(8'h10, 8'h04, 1'b0, 9'h00C, "b2b_sub");
    step(8'h10, 8'h04, 1'b1, 9'h014, "b2b_add1");

    // Reset pulse between edges, then release with inputs held.
    @(negedge clk);
    bus.x    = 8'h33;
    bus.y    = 8'h11;
    bus.flag = 1'b0;
    #1 rst = 1'b0;
    #1 check("midrst_clear", bus.z, 9'h000);
    #1 rst = 1'b1;
    #1 check("midrst_stay", bus.z, 9'h000);
    @(posedge clk);
    #1 check("midrst_resume", bus.z, 9'h022);
    prev = 9'h022;

    for (int i = 0; i < 200; i++) begin
      rx = WIDTH'($urandom);
      ry = WIDTH'($urandom);
      rf = 1'($urandom);
      step(rx, ry, rf, ref_model(rx, ry, rf), "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
